// File: rtl/vram_scanout_pkg.sv
// Shared constants and types for the VRAM scan-out block.
// Holds the default raster timing, the VRAM geometry, the pixels-per-word
// constant and the word-address helper used by the fetch scheduler.
package vram_scanout_pkg;

  // VRAM geometry, shared with the VRAM itself
  localparam int ADDR_W          = 10;
  localparam int WORD_W          = 16;
  localparam int VRAM_BASE       = 0;
  localparam int VRAM_WORDS      = 1024;
  localparam int PIXELS_PER_WORD = 16;

  // Default 128x128 raster timing (pixels / lines)
  localparam int H_ACTIVE_DEF = 128;
  localparam int H_FP_DEF     = 8;
  localparam int H_SYNC_DEF   = 16;
  localparam int H_BP_DEF     = 8;
  localparam int V_ACTIVE_DEF = 128;
  localparam int V_FP_DEF     = 2;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 10;

  // Registered video control bits that travel together down the pipeline
  typedef struct packed {
    logic blank;
    logic hsyncN;
    logic vsyncN;
  } videoCtrl_t;

  localparam videoCtrl_t VIDEO_IDLE = '{blank: 1'b1, hsyncN: 1'b1, vsyncN: 1'b1};

  // Word address of column group 'group' on raster line 'line'
  function automatic logic [ADDR_W-1:0] wordAddr(input logic [ADDR_W-1:0] line,
                                                 input logic [ADDR_W-1:0] group,
                                                 input int wordsPerLine);
    return line * ADDR_W'(wordsPerLine) + group;
  endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// Scan read port between the VRAM and the scan-out engine.
// The scan-out engine is the master: it issues a one-cycle read strobe with
// a word address and expects the data on the following cycle.
interface vram_scanout_if;
  import vram_scanout_pkg::*;

  logic              vram_rd_en;
  logic [ADDR_W-1:0] vram_addr;
  logic [WORD_W-1:0] vram_data;

  modport master (output vram_rd_en, output vram_addr, input vram_data);
  modport slave  (input vram_rd_en, input vram_addr, output vram_data);

endinterface

// File: rtl/vram_scanout_scan_counter.sv
// Module scan_counter: mod-N counter with enable, synchronous clear and a
// terminal-count pulse. Used for both the pixel and the line counter.
module scan_counter #(
  parameter int N = 160,
  parameter int W = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap at N-1
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  // Counter register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = en_i && !clr_i && (count_q == LAST);

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: walks a monochrome raster, fetches 16-bit words from the
// VRAM scan port and serialises them MSB-first with hsync/vsync/blank.
// Optional feature macro: VRAM_SCANOUT_FRAME_PULSE_EN adds a one-clock
// frame_pulse output at the start of vertical blank.
module vram_scanout
  import vram_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           scan_en,
  vram_scanout_if.master vram,
  output logic           pixel,
  output logic           blank,
  output logic           hsync_n,
  output logic           vsync_n
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  ,
  output logic           frame_pulse
`endif
);

  localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW             = $clog2(H_TOTAL);
  localparam int VW             = $clog2(V_TOTAL);
  localparam int GROUP_SHIFT    = $clog2(PIXELS_PER_WORD);
  localparam int WORDS_PER_LINE = H_ACTIVE / PIXELS_PER_WORD;

  localparam logic [HW-1:0] H_ACTIVE_C      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START_C  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END_C    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_FIRST_FETCH_C = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_LATER_LIMIT_C = HW'(H_ACTIVE - PIXELS_PER_WORD);
  localparam logic [VW-1:0] V_ACTIVE_C      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_ACTIVE_C = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_START_C  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END_C    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C        = VW'(V_TOTAL - 1);
  localparam logic [GROUP_SHIFT-1:0] FETCH_PHASE_C = GROUP_SHIFT'(PIXELS_PER_WORD - 2);

  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;
  logic          hWrap;
  logic          frameWrapUnused;

  logic              fetchFirst;
  logic              fetchLater;
  logic              fetch;
  logic [ADDR_W-1:0] nextLine;
  logic [ADDR_W-1:0] fetchAddr;
  logic              active;

  logic              rdEn_q, rdEn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dataValid_q, dataValid_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  videoCtrl_t        ctrl_q, ctrl_d;

  // Pixel counter runs while scanning; dropping scan_en parks it at 0
  scan_counter #(.N(H_TOTAL)) hCounter (
    .clock   (clock),
    .reset   (reset),
    .en_i    (scan_en),
    .clr_i   (!scan_en),
    .count_o (hCount),
    .tc_o    (hWrap)
  );

  // Line counter advances on each pixel-counter wrap; its own end-of-frame
  // pulse has no consumer here
  scan_counter #(.N(V_TOTAL)) vCounter (
    .clock   (clock),
    .reset   (reset),
    .en_i    (hWrap),
    .clr_i   (!scan_en),
    .count_o (vCount),
    .tc_o    (frameWrapUnused)
  );

  // Fetch scheduler: the strobe lands two clocks ahead of the first visible
  // pixel of its word. Group 0 of a line is fetched at the tail of the
  // previous line (line 0 from the last line of the frame), so right after
  // a start or restart the first group of line 0 has no data and shows 0.
  always_comb begin
    fetchFirst = (hCount == H_FIRST_FETCH_C) &&
                 ((vCount == V_LAST_C) || (vCount < V_LAST_ACTIVE_C));
    fetchLater = (vCount < V_ACTIVE_C) && (hCount < H_LATER_LIMIT_C) &&
                 (hCount[GROUP_SHIFT-1:0] == FETCH_PHASE_C);
    fetch      = fetchFirst || fetchLater;
    nextLine   = (vCount == V_LAST_C) ? '0 : ADDR_W'(vCount) + ADDR_W'(1);
    if (fetchFirst) begin
      fetchAddr = wordAddr(nextLine, '0, WORDS_PER_LINE);
    end else begin
      fetchAddr = wordAddr(ADDR_W'(vCount),
                           ADDR_W'(hCount >> GROUP_SHIFT) + ADDR_W'(1),
                           WORDS_PER_LINE);
    end
    active = (hCount < H_ACTIVE_C) && (vCount < V_ACTIVE_C);
  end

  // Next-state for the output pipeline; scan_en low returns everything to idle
  always_comb begin
    rdEn_d      = fetch;
    addr_d      = fetch ? fetchAddr : addr_q;
    dataValid_d = rdEn_q;
    shift_d     = shift_q;
    if (dataValid_q) begin
      shift_d = vram.vram_data;
    end else if (!ctrl_q.blank) begin
      shift_d = {shift_q[WORD_W-2:0], 1'b0};
    end
    ctrl_d.blank  = !active;
    ctrl_d.hsyncN = !((hCount >= H_SYNC_START_C) && (hCount < H_SYNC_END_C));
    ctrl_d.vsyncN = !((vCount >= V_SYNC_START_C) && (vCount < V_SYNC_END_C));
    if (!scan_en) begin
      rdEn_d      = 1'b0;
      addr_d      = '0;
      dataValid_d = 1'b0;
      shift_d     = '0;
      ctrl_d      = VIDEO_IDLE;
    end
  end

  // Pipeline registers; reset drops any read still in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdEn_q      <= 1'b0;
      addr_q      <= '0;
      dataValid_q <= 1'b0;
      shift_q     <= '0;
      ctrl_q      <= VIDEO_IDLE;
    end else begin
      rdEn_q      <= rdEn_d;
      addr_q      <= addr_d;
      dataValid_q <= dataValid_d;
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign vram.vram_rd_en = rdEn_q;
  assign vram.vram_addr  = ADDR_W'(VRAM_BASE) + addr_q;
  assign pixel           = shift_q[WORD_W-1] & ~ctrl_q.blank;
  assign blank           = ctrl_q.blank;
  assign hsync_n         = ctrl_q.hsyncN;
  assign vsync_n         = ctrl_q.vsyncN;

`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  logic framePulse_q, framePulse_d;

  // Start-of-vertical-blank marker, aligned with the other video outputs
  always_comb begin
    framePulse_d = scan_en && (hCount == '0) && (vCount == V_ACTIVE_C);
  end

  // Frame pulse register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      framePulse_q <= 1'b0;
    end else begin
      framePulse_q <= framePulse_d;
    end
  end

  assign frame_pulse = framePulse_q;
`endif

endmodule

// File: tb/tb_vram_scanout.sv
// Directed testbench for vram_scanout: two full frames against a raster
// model, a scan_en drop mid-frame, and a reset in the cycle after a read.
module tb_vram_scanout;
  import vram_scanout_pkg::*;

  localparam int H_TOT = 160;
  localparam int V_TOT = 144;
  localparam int FRAME = H_TOT * V_TOT;

  logic clock;
  logic reset;
  logic scan_en;
  logic pixel;
  logic blank;
  logic hsync_n;
  logic vsync_n;
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
  logic frame_pulse;
`endif

  vram_scanout_if vif();

  logic [WORD_W-1:0] mem [0:VRAM_WORDS-1];

  int checks;
  int fails;

  vram_scanout dut (
    .clock   (clock),
    .reset   (reset),
    .scan_en (scan_en),
    .vram    (vif),
    .pixel   (pixel),
    .blank   (blank),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n)
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
    ,
    .frame_pulse (frame_pulse)
`endif
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // VRAM scan port: data appears the cycle after the strobe and then holds
  always @(posedge clock) begin
    if (vif.vram_rd_en === 1'b1) vif.vram_data <= mem[vif.vram_addr];
  end

  task automatic applyStimulus(input logic rstVal, input logic enVal);
    reset   = rstVal;
    scan_en = enVal;
  endtask

  task automatic stepClock;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  int pos, fpos, x, y, expAddr;
  logic expActive, expHs, expVs, expPix, expRd;
  logic [WORD_W-1:0] w;
  int blankErrs, hsErrs, vsErrs, pixErrs, rdErrs;
  int reads, maxAddr, addr0Count, addr0Pos, hsLow, vsLow, activeCnt, ones0, ones1;
  logic px00, px01, px015, px016, px127a, px127b, px127c, px126;
  int fpCount, fpPos;
  int dropRd, dropBlankLow, dropSyncLow;
  int found, rdPos, rdAddr;
  int onesLow, onesMid, onesHigh;

  initial begin
    checks = 0; fails = 0;
    blankErrs = 0; hsErrs = 0; vsErrs = 0; pixErrs = 0; rdErrs = 0;
    reads = 0; maxAddr = 0; addr0Count = 0; addr0Pos = -1; hsLow = 0; vsLow = 0;
    activeCnt = 0; ones0 = 0; ones1 = 0; fpCount = 0; fpPos = -1;
    px00 = 0; px01 = 0; px015 = 0; px016 = 0; px127a = 0; px127b = 0; px127c = 0; px126 = 0;
    for (int i = 0; i < VRAM_WORDS; i++) mem[i] = '0;
    mem[0]    = 16'h8001;
    mem[1023] = 16'hFFFF;

    applyStimulus(1'b0, 1'b0);
    repeat (3) stepClock;
    checkOutput("reset_blank", blank, 1);
    checkOutput("reset_hsync_n", hsync_n, 1);
    checkOutput("reset_vsync_n", vsync_n, 1);
    checkOutput("reset_pixel", pixel, 0);
    checkOutput("reset_rd_en", vif.vram_rd_en, 0);
    checkOutput("reset_addr", vif.vram_addr, 0);
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
    checkOutput("reset_frame_pulse", frame_pulse, 0);
`endif

    // Two full frames; outputs sampled after edge i show raster position i-1
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 2 * FRAME; i++) begin
      stepClock;
      pos  = i - 1;
      fpos = pos % FRAME;
      x    = fpos % H_TOT;
      y    = fpos / H_TOT;
      expActive = (x < 128) && (y < 128);
      expHs     = !((x >= 136) && (x < 152));
      expVs     = !((y >= 130) && (y < 134));
      expPix    = 1'b0;
      if (expActive && (pos >= 16)) begin
        w = mem[y * 8 + x / 16];
        expPix = w[15 - (x % 16)];
      end
      expRd = 1'b0;
      expAddr = 0;
      if ((x == 158) && ((y == 143) || (y <= 126))) begin
        expRd = 1'b1;
        expAddr = (y == 143) ? 0 : (y + 1) * 8;
      end else if ((x < 112) && (x % 16 == 14) && (y < 128)) begin
        expRd = 1'b1;
        expAddr = y * 8 + x / 16 + 1;
      end
      if (blank !== !expActive) blankErrs++;
      if (hsync_n !== expHs) hsErrs++;
      if (vsync_n !== expVs) vsErrs++;
      if (pixel !== expPix) pixErrs++;
      if (vif.vram_rd_en !== expRd) rdErrs++;
      else if (expRd && (vif.vram_addr !== 10'(expAddr))) rdErrs++;
      if (pos < FRAME) begin
        if (pixel === 1'b1) ones0++;
      end else begin
        if (pixel === 1'b1) ones1++;
        if (vif.vram_rd_en === 1'b1) begin
          reads++;
          if (int'(vif.vram_addr) > maxAddr) maxAddr = int'(vif.vram_addr);
          if (vif.vram_addr == 0) begin
            addr0Count++;
            addr0Pos = fpos;
          end
        end
        if (hsync_n === 1'b0) hsLow++;
        if (vsync_n === 1'b0) vsLow++;
        if (blank === 1'b0) activeCnt++;
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
        if (frame_pulse === 1'b1) begin
          fpCount++;
          fpPos = fpos;
        end
`endif
        case (fpos)
          0:     px00   = pixel;
          1:     px01   = pixel;
          15:    px015  = pixel;
          16:    px016  = pixel;
          20431: px127a = pixel;
          20432: px127b = pixel;
          20447: px127c = pixel;
          20287: px126  = pixel;
          default: ;
        endcase
      end
    end
    checkOutput("blank_vs_model_errs", blankErrs, 0);
    checkOutput("hsync_vs_model_errs", hsErrs, 0);
    checkOutput("vsync_vs_model_errs", vsErrs, 0);
    checkOutput("pixel_vs_model_errs", pixErrs, 0);
    checkOutput("read_vs_model_errs", rdErrs, 0);
    checkOutput("reads_per_frame", reads, 1024);
    checkOutput("max_read_addr", maxAddr, 1023);
    checkOutput("addr0_reads_per_frame", addr0Count, 1);
    checkOutput("addr0_read_pos", addr0Pos, 143 * 160 + 158);
    checkOutput("hsync_low_clocks", hsLow, 144 * 16);
    checkOutput("vsync_low_clocks", vsLow, 4 * 160);
    checkOutput("active_clocks", activeCnt, 128 * 128);
    checkOutput("ones_first_frame", ones0, 16);
    checkOutput("ones_second_frame", ones1, 18);
    checkOutput("pixel_line0_x0", px00, 1);
    checkOutput("pixel_line0_x1", px01, 0);
    checkOutput("pixel_line0_x15", px015, 1);
    checkOutput("pixel_line0_x16", px016, 0);
    checkOutput("pixel_line127_x111", px127a, 0);
    checkOutput("pixel_line127_x112", px127b, 1);
    checkOutput("pixel_line127_x127", px127c, 1);
    checkOutput("pixel_line126_x127", px126, 0);
`ifdef VRAM_SCANOUT_FRAME_PULSE_EN
    checkOutput("frame_pulse_count", fpCount, 1);
    checkOutput("frame_pulse_pos", fpPos, 128 * 160);
`endif

    // Run into frame 3 up to line 50, x=70, then drop scan_en for 10 clocks
    mem[1] = 16'hFFFF;
    repeat (50 * 160 + 70) stepClock;
    checkOutput("pre_drop_blank", blank, 0);
    applyStimulus(1'b1, 1'b0);
    stepClock;
    checkOutput("drop_blank", blank, 1);
    checkOutput("drop_hsync_n", hsync_n, 1);
    checkOutput("drop_vsync_n", vsync_n, 1);
    checkOutput("drop_pixel", pixel, 0);
    checkOutput("drop_rd_en", vif.vram_rd_en, 0);
    dropRd = 0; dropBlankLow = 0; dropSyncLow = 0;
    repeat (9) begin
      stepClock;
      if (vif.vram_rd_en !== 1'b0) dropRd++;
      if (blank !== 1'b1) dropBlankLow++;
      if ((hsync_n !== 1'b1) || (vsync_n !== 1'b1)) dropSyncLow++;
    end
    checkOutput("drop_reads", dropRd, 0);
    checkOutput("drop_blank_low", dropBlankLow, 0);
    checkOutput("drop_sync_low", dropSyncLow, 0);

    // Restart: fresh frame at line 0; first fetch is group 1 of line 0
    applyStimulus(1'b1, 1'b1);
    found = 0; rdPos = -1; rdAddr = -1;
    for (int j = 1; j <= 40; j++) begin
      stepClock;
      if (j == 1) begin
        checkOutput("restart_blank_line0_x0", blank, 0);
        checkOutput("restart_vsync_n", vsync_n, 1);
      end
      if (vif.vram_rd_en === 1'b1) begin
        found = 1;
        rdPos = j - 1;
        rdAddr = int'(vif.vram_addr);
        break;
      end
    end
    checkOutput("restart_read_found", found, 1);
    checkOutput("restart_read_pos", rdPos, 14);
    checkOutput("restart_read_addr", rdAddr, 1);

    // Reset in the cycle after that read, while FFFF sits on the data bus
    stepClock;
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("midfetch_reset_blank", blank, 1);
    checkOutput("midfetch_reset_hsync_n", hsync_n, 1);
    checkOutput("midfetch_reset_vsync_n", vsync_n, 1);
    checkOutput("midfetch_reset_pixel", pixel, 0);
    checkOutput("midfetch_reset_rd_en", vif.vram_rd_en, 0);
    checkOutput("midfetch_reset_addr", vif.vram_addr, 0);
    repeat (3) stepClock;
    applyStimulus(1'b1, 1'b1);
    onesLow = 0; onesMid = 0; onesHigh = 0;
    for (int j = 1; j <= 40; j++) begin
      stepClock;
      if (pixel === 1'b1) begin
        if (j - 1 < 16) onesLow++;
        else if (j - 1 < 32) onesMid++;
        else onesHigh++;
      end
    end
    checkOutput("post_reset_stale_ones_x0_15", onesLow, 0);
    checkOutput("post_reset_ones_x16_31", onesMid, 16);
    checkOutput("post_reset_ones_x32_39", onesHigh, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
